// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; full/empty/count decode straight
// from the pointer flops, so they move in the cycle after a push or pop edge.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A full FIFO refuses pushes even if a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: FIFO-buffered bytes serialised as 8N1 frames.
// Define UART_TX_PARITY_EN to add a parity bit (port parity_odd, state PARITY).
//
// state  | meaning
// IDLE   | line high, waiting for tx_en and a queued byte
// START  | start bit (low) for one bit period
// DATA   | eight data bits, LSB first
// PARITY | parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit (high); may chain straight into the next START
module uart_tx_engine #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic                          tx_en,
  input  logic                          ovf_clr,
`ifdef UART_TX_PARITY_EN
  input  logic                          parity_odd,
`endif
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          tx_o,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic                          overflow
);

  import uart_pkg::*;

  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

  uart_tx_state_e               state_q;
  logic [UART_DATA_BITS-1:0]    shift_q;
  logic [DIV_WIDTH-1:0]         div_q;
  logic [DIV_WIDTH-1:0]         baud_cnt_q;
  logic [BW-1:0]                bit_cnt_q;
  logic                         tx_q;
  logic                         overflow_q;
  logic [UART_DATA_BITS-1:0]    fifo_head;
  logic                         baud_end;
  logic                         start_frame;
  logic                         tx_bit_d;
`ifdef UART_TX_PARITY_EN
  logic                         parity_q;
`endif

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk_i   (S_AXI_ACLK),
    .rst_ni  (S_AXI_ARESETN),
    .push_i  (wr_valid),
    .data_i  (wr_data),
    .pop_i   (start_frame),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign wr_ready = !fifo_full;
  assign overflow = overflow_q;
  assign tx_o     = tx_q;
  assign tx_busy  = (state_q != IDLE);

  assign baud_end    = (baud_cnt_q == div_q);
  // Frames start from IDLE or chain from the last cycle of STOP with no gap.
  assign start_frame = tx_en && !fifo_empty &&
                       ((state_q == IDLE) || ((state_q == STOP) && baud_end));

  always_comb begin
    tx_bit_d = UART_IDLE_LEVEL;
    case (state_q)
      START:   tx_bit_d = 1'b0;
      DATA:    tx_bit_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_bit_d = parity_q;
`endif
      default: tx_bit_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      div_q      <= '0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      // Line level follows the state one cycle later, straight from this flop.
      tx_q <= tx_bit_d;
      if (start_frame) begin
        state_q    <= START;
        shift_q    <= fifo_head;
        div_q      <= baud_div;
        baud_cnt_q <= '0;
        bit_cnt_q  <= '0;
`ifdef UART_TX_PARITY_EN
        parity_q   <= ^fifo_head ^ parity_odd;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            baud_cnt_q <= '0;
          end
          START: begin
            if (baud_end) begin
              baud_cnt_q <= '0;
              bit_cnt_q  <= '0;
              state_q    <= DATA;
            end else begin
              baud_cnt_q <= baud_cnt_q + DIV_WIDTH'(1);
            end
          end
          DATA: begin
            if (baud_end) begin
              baud_cnt_q <= '0;
              shift_q    <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
              if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end else begin
                bit_cnt_q <= bit_cnt_q + BW'(1);
              end
            end else begin
              baud_cnt_q <= baud_cnt_q + DIV_WIDTH'(1);
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            if (baud_end) begin
              baud_cnt_q <= '0;
              state_q    <= STOP;
            end else begin
              baud_cnt_q <= baud_cnt_q + DIV_WIDTH'(1);
            end
          end
`endif
          STOP: begin
            if (baud_end) begin
              baud_cnt_q <= '0;
              state_q    <= IDLE;
            end else begin
              baud_cnt_q <= baud_cnt_q + DIV_WIDTH'(1);
            end
          end
          default: begin
            baud_cnt_q <= '0;
            state_q    <= IDLE;
          end
        endcase
      end
    end
  end

  // Set wins over a coincident clear.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      overflow_q <= 1'b0;
    end else if (wr_valid && fifo_full) begin
      overflow_q <= 1'b1;
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Transmit path of the AXI4-Lite UART peripheral. Sits directly downstream of the S00_AXI register slave: accepts bytes written to the TX data register through a valid/ready port, buffers them in a FIFO, and serialises each as an 8N1 frame on `tx_o` at a programmable baud rate. It also returns FIFO status and a sticky overflow flag to the status register.

## Interface
- `FIFO_DEPTH`, 16: TX FIFO entries; power of two, at least 2.
- `DIV_WIDTH`, 16: width of the baud divisor.
- `S_AXI_ACLK  in  1`: the single clock; all logic is rising-edge.
- `S_AXI_ARESETN  in  1`: reset, asynchronous and active-low.
- `baud_div  in  DIV_WIDTH`: clocks per bit minus 1.
- `tx_en  in  1`: enables frame start.
- `ovf_clr  in  1`: one-cycle clear of `overflow`.
- `wr_valid  in  1`: byte offered by the register slave.
- `wr_data  in  8`: byte to send.
- `wr_ready  out  1`: FIFO can accept a byte.
- `tx_o  out  1`: serial line; idle high.
- `tx_busy  out  1`: a frame is in progress.
- `fifo_count  out  $clog2(FIFO_DEPTH)+1`: occupied entries.
- `fifo_empty  out  1`: FIFO is empty.
- `fifo_full  out  1`: FIFO is full.
- `overflow  out  1`: sticky flag; a write was offered while the FIFO was full.
- `parity_odd  in  1`: selects odd parity. Present only with `UART_TX_PARITY_EN`.

## Operation
- **Reset values:** `tx_o`=1, `tx_busy`=0, `wr_ready`=1, `fifo_count`=0, `fifo_empty`=1, `fifo_full`=0, `overflow`=0, FSM in IDLE.
- **Push:** occurs on `wr_valid && wr_ready`. `wr_ready` = !`fifo_full`, which is registered, so a same-cycle pop does not make room.
- **Overflow:** `wr_valid && fifo_full` sets `overflow`. `ovf_clr` clears it. If set and clear occur in the same cycle, set wins.
- **FSM states:** IDLE, START, DATA, [PARITY], STOP.
- **IDLE → START:** when `tx_en && !fifo_empty`. This transition pops the head byte into a shift register and latches `baud_div` into `div_q`. `div_q` is held for the whole frame.
- **Bit period:** every bit lasts `div_q+1` cycles, counted by `baud_cnt` running from 0 to `div_q`.
- **START:** drives `tx_o`=0 for one bit period, then goes to DATA.
- **DATA:** sends 8 bits LSB first. `bit_cnt` runs 0..7. After bit 7 the FSM goes to STOP, or to PARITY when that feature is compiled in.
- **STOP:** drives `tx_o`=1 for one bit period. At the end of STOP:
  - if `tx_en && !fifo_empty`, pop and go directly to START, with no idle gap;
  - otherwise go to IDLE.
- **Dropping `tx_en` mid-frame:** the current frame completes; no new frame starts.
- **`tx_busy`:** 1 in every state except IDLE.
- **Reset mid-frame:** `tx_o` returns to 1 immediately (asynchronously). The FIFO is emptied and the frame is discarded.
- **`baud_div` = 0:** each bit lasts 1 cycle, giving a 10-cycle frame.

## Timing
- **Push latency:** `fifo_count`, `fifo_empty` and `fifo_full` update in the cycle after the push edge.
- **Start latency:** with the engine in IDLE, `tx_en`=1 and the FIFO non-empty at edge N, `tx_o` falls after edge N+1 (one cycle to pop and register).
- **Frame length:** 10×(`div_q`+1) cycles, or 11×(`div_q`+1) with parity.
- **Simultaneous push and pop:** when not full, `fifo_count` is unchanged.
- **Pointer wrap:** read and write pointers are `$clog2(FIFO_DEPTH)`+1 bits. Full means the MSBs differ and the remaining bits are equal.
- **Glitch-free line:** `tx_o` is driven directly from a flop.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - adds the `parity_odd` port and the PARITY state between DATA and STOP;
  - the parity bit is `^data ^ parity_odd` (even parity when `parity_odd`=0);
  - the frame is 11 bits.
- `UART_TX_PARITY_EN` undefined:
  - the port and state are absent;
  - the frame is 8N1, 10 bits.

## Structure
- **Package `uart_pkg`:**
  - typedef `uart_tx_state_e` (IDLE, START, DATA, PARITY, STOP);
  - constant `UART_DATA_BITS`=8;
  - constant `UART_IDLE_LEVEL`=1'b1.
- **Sub-module `uart_sync_fifo`:** a parameterised synchronous FIFO providing push, pop, count, full and empty. The engine instantiates it and contains only the FSM, the counters and the shift register.

## Test plan
- **Single byte, 8N1:** reset, `baud_div`=3, `tx_en`=1, push 0xA5.
  - `tx_o` falls 2 cycles after the push edge;
  - bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles;
  - `tx_busy` is high for exactly 40 cycles.
- **Back-to-back:** push 0x00, 0xFF, 0x55 with `baud_div`=0.
  - three contiguous 10-cycle frames with no idle cycles between stop and start;
  - `fifo_empty` rises after the third pop.
- **Full and overflow:** `tx_en`=0, push 17 bytes with `FIFO_DEPTH`=16.
  - `fifo_full`=1 and `fifo_count`=16;
  - the 17th byte is not accepted and `overflow`=1;
  - pulse `ovf_clr` → `overflow`=0;
  - when `ovf_clr` coincides with another write while full → `overflow` stays 1.
- **Divisor change and `tx_en` drop mid-frame:**
  - change `baud_div` from 3 to 7 during frame 1 → frame 1 keeps 4-cycle bits; frame 2 uses 8-cycle bits;
  - drop `tx_en` during frame 2 → frame 2 completes and `tx_o` stays 1 afterwards.
- **Reset mid-frame:** assert `S_AXI_ARESETN`=0 during DATA with 3 bytes queued.
  - `tx_o`=1 immediately, `fifo_count`=0, `tx_busy`=0;
  - after release, nothing is transmitted.
- **Parity (`UART_TX_PARITY_EN`):** 0x07 with `parity_odd`=0 → parity bit 1; 0x03 with `parity_odd`=1 → parity bit 1; frame is 11 bits.
